// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared constants for the seven-segment scanner. It holds the active-low
// segment codes, the dash glyph, the cathode bit order and a small helper
// that packs segments and a decimal point into one cathode byte.
// No ports (package).
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  // The cathode byte is {a,b,c,d,e,f,g,dp}. Every bit is active-low.
  localparam int CATH_W  = 8;
  localparam int CATH_A  = 7;
  localparam int CATH_G  = 1;
  localparam int CATH_DP = 0;

  localparam logic [CATH_W-1:0] CATH_OFF = 8'hFF;

  // Segment codes, {a..g}, with 0 = segment lit
  localparam seg_t SEG_0    = 7'b0000001;
  localparam seg_t SEG_1    = 7'b1001111;
  localparam seg_t SEG_2    = 7'b0010010;
  localparam seg_t SEG_3    = 7'b0000110;
  localparam seg_t SEG_4    = 7'b1001100;
  localparam seg_t SEG_5    = 7'b0100100;
  localparam seg_t SEG_6    = 7'b0100000;
  localparam seg_t SEG_7    = 7'b0001111;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0000100;
  localparam seg_t SEG_A    = 7'b0001000;
  localparam seg_t SEG_B    = 7'b1100000;
  localparam seg_t SEG_C    = 7'b0110001;
  localparam seg_t SEG_D    = 7'b1000010;
  localparam seg_t SEG_E    = 7'b0110000;
  localparam seg_t SEG_F    = 7'b0111000;
  localparam seg_t SEG_DASH = 7'b1111110;

  function automatic logic [CATH_W-1:0] pack_cathode(input seg_t seg, input logic dp_lit);
    logic [CATH_W-1:0] c;
    c                 = CATH_OFF;
    c[CATH_A:CATH_G]  = seg;
    c[CATH_DP]        = ~dp_lit;
    return c;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// sevenseg_decode
// This is a combinational nibble-to-segment decoder.
//   nibble   in  4  value to show
//   hex_mode in  1  1 = show 10..15 as A,b,C,d,E,F; 0 = show them as a dash
//   seg      out 7  {a..g}, active-low
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg_t       seg
);

  seg_t hex_seg;

  always_comb begin
    hex_seg = SEG_DASH;
    case (nibble)
      4'h0: hex_seg = SEG_0;
      4'h1: hex_seg = SEG_1;
      4'h2: hex_seg = SEG_2;
      4'h3: hex_seg = SEG_3;
      4'h4: hex_seg = SEG_4;
      4'h5: hex_seg = SEG_5;
      4'h6: hex_seg = SEG_6;
      4'h7: hex_seg = SEG_7;
      4'h8: hex_seg = SEG_8;
      4'h9: hex_seg = SEG_9;
      4'hA: hex_seg = SEG_A;
      4'hB: hex_seg = SEG_B;
      4'hC: hex_seg = SEG_C;
      4'hD: hex_seg = SEG_D;
      4'hE: hex_seg = SEG_E;
      4'hF: hex_seg = SEG_F;
      default: hex_seg = SEG_DASH;
    endcase
  end

  assign seg = (!hex_mode && nibble > 4'd9) ? SEG_DASH : hex_seg;

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan
// This module drives a multiplexed seven-segment display. Each digit is
// selected for DIGIT_CYCLES clocks. The first BLANK_CYCLES clocks of each
// slot are dark so that no ghosting occurs. Display data is written into
// staging registers. It is committed to the display registers only at a frame
// boundary, so a single frame never mixes old and new data.
//   clk        in  1            system clock, rising edge
//   clr        in  1            async reset, active-high
//   load       in  1            strobe that captures digits/dp_in/blink_en into staging
//   digits     in  4*NUM_DIGITS one nibble per digit, digit 0 = bits [3:0], rightmost
//   dp_in      in  NUM_DIGITS   decimal point per digit, 1 = lit
//   blink_en   in  NUM_DIGITS   blink request per digit
//   hex_mode   in  1            1 = hex glyphs for 10..15, 0 = dash
//   lz_blank   in  1            leading-zero suppression, sampled live
//   pending    out 1            staged data not yet committed
//   frame_tick out 1            high during the cycle in which the scan wraps to digit 0
//   cathode    out 8            {a..g,dp}, active-low, registered
//   anode      out NUM_DIGITS   one-hot active-low digit select, registered
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 65536,
  parameter int BLANK_CYCLES = 256,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [CATH_W-1:0]       cathode,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT_W  = $clog2(DIGIT_CYCLES);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]  SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blink_q, disp_blink_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [CATH_W-1:0]       cathode_q, cathode_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_lead;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic                    sel_blink;
  logic                    sel_lz;
  seg_t                    sel_seg;

  // Scan position
  always_comb begin
    slot_end   = (slot_q == SLOT_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    slot_d     = slot_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Staging and commit. The commit reads the old staging values, so a load
  // that coincides with the wrap is kept for the next frame.
  always_comb begin
    stg_digits_d  = stg_digits_q;
    stg_dp_d      = stg_dp_q;
    stg_blink_d   = stg_blink_q;
    pending_d     = pending_q;
    disp_digits_d = disp_digits_q;
    disp_dp_d     = disp_dp_q;
    disp_blink_d  = disp_blink_q;
    if (frame_wrap && pending_q) begin
      disp_digits_d = stg_digits_q;
      disp_dp_d     = stg_dp_q;
      disp_blink_d  = stg_blink_q;
      pending_d     = 1'b0;
    end
    if (load) begin
      stg_digits_d = digits;
      stg_dp_d     = dp_in;
      stg_blink_d  = blink_en;
      pending_d    = 1'b1;
    end
  end

  // Blink phase: it toggles once for every BLINK_FRAMES frame wraps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Leading-zero mask. It walks down from the top digit and stays set until
  // the first nonzero nibble. Digit 0 is never part of the walk.
  always_comb begin
    lz_mask = '0;
    lz_lead = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_digits_q[4*i +: 4] != 4'd0) lz_lead = 1'b0;
      lz_mask[i] = lz_lead;
    end
  end

  // Select the current digit
  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_blink  = 1'b0;
    sel_lz     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nibble = disp_digits_q[4*i +: 4];
        sel_dp     = disp_dp_q[i];
        sel_blink  = disp_blink_q[i];
        sel_lz     = lz_mask[i];
      end
    end
  end

  sevenseg_decode u_decode (
    .nibble   (sel_nibble),
    .hex_mode (hex_mode),
    .seg      (sel_seg)
  );

  // A blinked digit turns off its anode as well. A leading-zero digit keeps
  // its anode slot, but all of its cathodes, dp included, are off.
  always_comb begin
    anode_d   = '1;
    cathode_d = CATH_OFF;
    if (slot_q >= SLOT_BLANK && !(blink_phase_q && sel_blink)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        anode_d[i] = (idx_q != IDX_W'(i));
      end
      if (!sel_lz) cathode_d = pack_cathode(sel_seg, sel_dp);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      slot_q        <= '0;
      idx_q         <= '0;
      stg_digits_q  <= '0;
      stg_dp_q      <= '0;
      stg_blink_q   <= '0;
      pending_q     <= 1'b0;
      disp_digits_q <= '0;
      disp_dp_q     <= '0;
      disp_blink_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      cathode_q     <= CATH_OFF;
      anode_q       <= '1;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      stg_digits_q  <= stg_digits_d;
      stg_dp_q      <= stg_dp_d;
      stg_blink_q   <= stg_blink_d;
      pending_q     <= pending_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      disp_blink_q  <= disp_blink_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      cathode_q     <= cathode_d;
      anode_q       <= anode_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_wrap;
  assign cathode    = cathode_q;
  assign anode      = anode_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
// This is a directed bench for sevenseg_scan, with 4 digits, 8-cycle slots, 2 blank cycles
// and a 2-frame blink.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_en = '0;
  logic        hex_mode = 1'b0;
  logic        lz_blank = 1'b0;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  cathode;
  logic [3:0]  anode;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(
    .NUM_DIGITS   (4),
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .load       (load),
    .digits     (digits),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .hex_mode   (hex_mode),
    .lz_blank   (lz_blank),
    .pending    (pending),
    .frame_tick (frame_tick),
    .cathode    (cathode),
    .anode      (anode)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits   = d;
    dp_in    = dp;
    blink_en = bl;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Returns at the negedge of a frame_tick cycle, or fails after a bounded wait.
  task automatic sync_frame(input string tag);
    int k;
    k = 0;
    step(1);
    while (frame_tick !== 1'b1 && k < 80) begin
      step(1);
      k++;
    end
    chk({tag, "_sync"}, {7'd0, frame_tick}, 8'd1);
  endtask

  // Entered at the negedge of a frame_tick cycle (ofs = cycles already spent past
  // it). It checks one frame and leaves at the negedge of the next frame_tick cycle.
  // cath holds one expected byte per digit (digit 0 in [7:0]). en = anode expected to be active.
  task automatic check_frame(input logic [31:0] cath, input logic [3:0] en, input int ofs,
                             input string tag);
    logic [3:0] exp_an;
    logic [7:0] exp_c;
    step(2 - ofs);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step(2);
      chk($sformatf("%s_d%0d_blank_an", tag, d), {4'd0, anode}, 8'h0F);
      chk($sformatf("%s_d%0d_blank_cath", tag, d), cathode, 8'hFF);
      step(2);
      exp_an = en[d] ? ~(4'b0001 << d) : 4'hF;
      exp_c  = en[d] ? cath[8*d +: 8] : 8'hFF;
      chk($sformatf("%s_d%0d_an", tag, d), {4'd0, anode}, {4'd0, exp_an});
      chk($sformatf("%s_d%0d_cath", tag, d), cathode, exp_c);
      chk($sformatf("%s_d%0d_ftick_low", tag, d), {7'd0, frame_tick}, 8'd0);
      step(4);
      chk($sformatf("%s_d%0d_an_late", tag, d), {4'd0, anode}, {4'd0, exp_an});
      chk($sformatf("%s_d%0d_cath_late", tag, d), cathode, exp_c);
    end
    chk({tag, "_ftick_32"}, {7'd0, frame_tick}, 8'd1);
  endtask

  initial begin
    // Reset values while clr is applied, before any clock edge
    #1 clr = 1'b1;
    #1;
    chk("rst_anode", {4'd0, anode}, 8'h0F);
    chk("rst_cath", cathode, 8'hFF);
    chk("rst_pending", {7'd0, pending}, 8'd0);
    chk("rst_ftick", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    clr = 1'b0;

    // Scan of 1234. Expected cathodes: 4=99, 3=0D, 2=25, 1=9F.
    load_pulse(16'h1234, 4'h0, 4'h0);
    chk("scan_pending_set", {7'd0, pending}, 8'd1);
    sync_frame("scan");
    chk("scan_pending_at_tick", {7'd0, pending}, 8'd1);
    check_frame({8'h9F, 8'h25, 8'h0D, 8'h99}, 4'hF, 0, "scan");
    chk("scan_pending_clear", {7'd0, pending}, 8'd0);

    // Tear-free: load 5678 in mid-frame; the rest of this frame stays 1234.
    step(10);
    load_pulse(16'h5678, 4'h0, 4'h0);
    chk("tear_pending", {7'd0, pending}, 8'd1);
    step(17);
    chk("tear_old_d3_an", {4'd0, anode}, 8'h07);
    chk("tear_old_d3_cath", cathode, 8'h9F);
    step(4);
    chk("tear_ftick", {7'd0, frame_tick}, 8'd1);
    chk("tear_pending_at_tick", {7'd0, pending}, 8'd1);
    check_frame({8'h49, 8'h41, 8'h1F, 8'h01}, 4'hF, 0, "tear");
    chk("tear_pending_clear", {7'd0, pending}, 8'd0);

    // Load during the frame_tick cycle: 9876 commits, 1234 stays pending.
    step(10);
    load_pulse(16'h9876, 4'h0, 4'h0);
    step(21);
    chk("coinc_ftick", {7'd0, frame_tick}, 8'd1);
    load_pulse(16'h1234, 4'h0, 4'h0);
    check_frame({8'h09, 8'h01, 8'h1F, 8'h41}, 4'hF, 1, "coinc_old");
    chk("coinc_pending_kept", {7'd0, pending}, 8'd1);
    check_frame({8'h9F, 8'h25, 8'h0D, 8'h99}, 4'hF, 0, "coinc_new");
    chk("coinc_pending_clear", {7'd0, pending}, 8'd0);

    // Hex mode and leading zeros on 00AF
    do_reset();
    hex_mode = 1'b0;
    lz_blank = 1'b1;
    load_pulse(16'h00AF, 4'h0, 4'h0);
    sync_frame("lz");
    check_frame({8'hFF, 8'hFF, 8'hFD, 8'hFD}, 4'hF, 0, "lz_dash");
    hex_mode = 1'b1;
    check_frame({8'hFF, 8'hFF, 8'h11, 8'h71}, 4'hF, 0, "lz_hex");
    lz_blank = 1'b0;
    check_frame({8'h03, 8'h03, 8'h11, 8'h71}, 4'hF, 0, "nolz_hex");

    // Blink and dp on digit 0 of 0000. The first frame after the commit is
    // visible, the next two are dark, then it is visible again.
    do_reset();
    hex_mode = 1'b0;
    lz_blank = 1'b1;
    load_pulse(16'h0000, 4'b0001, 4'b0001);
    sync_frame("blink");
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'h02}, 4'hF, 0, "blink_on1");
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'hE, 0, "blink_off1");
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'hE, 0, "blink_off2");
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'h02}, 4'hF, 0, "blink_on2");

    // clr in slot 2 while data is pending
    load_pulse(16'h1111, 4'h0, 4'h0);
    step(19);
    chk("clr_pending_before", {7'd0, pending}, 8'd1);
    clr = 1'b1;
    #1;
    chk("clr_anode", {4'd0, anode}, 8'h0F);
    chk("clr_cath", cathode, 8'hFF);
    chk("clr_pending", {7'd0, pending}, 8'd0);
    chk("clr_ftick", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    clr = 1'b0;
    step(2);
    chk("rel_slot1_an", {4'd0, anode}, 8'h0F);
    chk("rel_slot1_cath", cathode, 8'hFF);
    step(1);
    chk("rel_slot2_an", {4'd0, anode}, 8'h0E);
    chk("rel_slot2_cath", cathode, 8'h03);
    sync_frame("rel");
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'h03}, 4'hF, 0, "rel_discard");
    chk("rel_pending", {7'd0, pending}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
